key_click_counter: RTL and testbench
====================================

# key_click_counter

Sits directly downstream of the key debouncer and consumes its one-cycle press strobe. Groups presses that arrive within a configurable inter-press window into a single click event, e.g. single, double or triple click. Reports the group size with a one-cycle valid strobe, so control logic can map multi-click gestures to commands without its own timers.

## Interface
- CLK_FREQ_MHZ, 100: clock frequency in MHz; must match the debouncer's setting.
- WINDOW_US, 300000: maximum gap between consecutive presses of one group, in µs.
- MAX_CLICKS, 3: group size that closes a group immediately; ≥2.
- Derived localparam W = WINDOW_US * CLK_FREQ_MHZ (window length in cycles); W ≥ 2, checked by elaboration assertion.
- Derived localparam CNT_W = $clog2(MAX_CLICKS+1).

- clk_i, input, 1: single clock for the block.
- rst_i, input, 1: asynchronous, active-high reset.
- key_pressed_stb_i, input, 1: one-cycle press strobe from the debouncer; synchronous to clk_i.
- click_cnt_o, output, CNT_W: number of presses in the completed group; meaningful only while click_valid_o is high.
- click_valid_o, output, 1: one-cycle strobe marking a completed group.
- busy_o, output, 1: high while a group is open.

## Operation
- FSM states: IDLE and COUNT. Registers: state, cnt (CNT_W), timer ($clog2(W)), click_cnt_o, click_valid_o.
- IDLE + strobe: cnt←1, timer←0, go to COUNT.
- COUNT + strobe:
  - If cnt+1 == MAX_CLICKS: click_cnt_o←MAX_CLICKS, click_valid_o←1, go to IDLE.
  - Otherwise: cnt←cnt+1, timer←0.
- COUNT, no strobe, timer == W-1: click_cnt_o←cnt, click_valid_o←1, go to IDLE.
- COUNT, no strobe, timer < W-1: timer←timer+1.
- Strobe and timeout in the same cycle: the strobe wins. The press is counted and the window restarts.
- click_valid_o is forced to 0 on every edge that does not close a group.
- click_cnt_o holds its last value between strobes.
- busy_o = (state == COUNT), combinational from the state register.
- Strobe in the cycle where click_valid_o is high: the FSM is already IDLE, so the press starts a new group. No press is lost.
- cnt never exceeds MAX_CLICKS; no wrap-around is possible.
- Input strobe is assumed one-cycle. A level held high counts one press per cycle (debouncer contract).

## Timing
- Reset values: state IDLE; cnt, timer, click_cnt_o = 0; click_valid_o = 0; busy_o = 0.
- Reset mid-group discards the group. No valid is produced for it.
- Strobe sampled at edge k in IDLE: busy_o high after edge k.
- Last strobe of a group sampled at edge k:
  - Further strobes at edges k+1..k+W extend the group.
  - If none arrive, click_valid_o is high for exactly the cycle after edge k+W.
- Strobe reaching MAX_CLICKS at edge k: click_valid_o high for the cycle after edge k. busy_o is low in that same cycle.
- Latency from the deciding edge to valid: 0 cycles (registered outputs are set on that edge).

## Structure
- Shared package key_pkg holds:
  - the state enum click_state_t {IDLE, COUNT};
  - a function window_cycles(freq_mhz, window_us), also reusable by the debouncer for its glitch count.
- No sub-module: the timer and counter are tightly coupled to the FSM. Keep the block flat, in one always_ff plus one always_comb.

## Test plan
Parameters: CLK_FREQ_MHZ=1, WINDOW_US=10 (W=10), MAX_CLICKS=3.
- Single strobe at edge 5 -> click_valid_o high after edge 15 only, click_cnt_o=1. busy_o high after edges 5..14.
- Strobes at edges 5 and 12 -> single valid after edge 22, click_cnt_o=2.
- Strobes at edges 5, 8, 11 -> valid after edge 11, click_cnt_o=3. busy_o low in that cycle.
- Strobe at edge 5, then a strobe at edge 15 (coincides with the timeout) -> no valid at 15, valid after edge 25 with click_cnt_o=2.
- Strobes at edges 5, 8, 11, 12 -> valid(3) after edge 11, then a new group: valid(1) after edge 22.
- Strobe at edge 5, rst_i pulsed between edges 7 and 8 -> all outputs 0 immediately. No valid through edge 40.
- 2000 cycles of random sparse strobes checked against a cycle-accurate scoreboard model -> every valid and count matches.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key input path (debouncer, click counter).
//   click_state_t  : click counter FSM states.
//   window_cycles  : converts a time window in microseconds to clock cycles.
package key_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } click_state_t;

  function automatic int unsigned window_cycles(input int unsigned freq_mhz,
                                                input int unsigned window_us);
    return freq_mhz * window_us;
  endfunction

endpackage

// File: rtl/key_click_counter_if.sv
// Press-strobe in / click-event out bundle of the click counter.
//   key_pressed_stb_i : one-cycle press strobe (from debouncer)
//   click_cnt_o       : size of the completed group (valid with click_valid_o)
//   click_valid_o     : one-cycle strobe, group completed
//   busy_o            : a group is currently open
// master: upstream / consumer side; slave: the click counter itself.
interface key_click_counter_if
  import key_pkg::*;
#(
  parameter int CNT_W = 2
);
  logic             key_pressed_stb_i;
  logic [CNT_W-1:0] click_cnt_o;
  logic             click_valid_o;
  logic             busy_o;

  modport master (
    output key_pressed_stb_i,
    input  click_cnt_o,
    input  click_valid_o,
    input  busy_o
  );

  modport slave (
    input  key_pressed_stb_i,
    output click_cnt_o,
    output click_valid_o,
    output busy_o
  );
endinterface

// File: rtl/key_click_counter.sv
// Groups debounced key presses that arrive within WINDOW_US of each other into
// one click event (single/double/triple...) and reports the group size.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : key_click_counter_if.slave (strobe in; count, valid, busy out)
// A group closes either when the window after its last press expires
// (click_cnt_o = presses so far) or immediately when MAX_CLICKS is reached.
module key_click_counter
  import key_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int WINDOW_US    = 300000,
  parameter int MAX_CLICKS   = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  key_click_counter_if.slave   bus
);

  localparam int W       = int'(window_cycles(CLK_FREQ_MHZ, WINDOW_US));
  localparam int CNT_W   = $clog2(MAX_CLICKS + 1);
  localparam int TIMER_W = $clog2(W);

  if (W < 2) begin : g_chk_window
    $error("key_click_counter: window must be at least 2 cycles");
  end
  if (MAX_CLICKS < 2) begin : g_chk_max
    $error("key_click_counter: MAX_CLICKS must be at least 2");
  end

  click_state_t       state_q,       state_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic [TIMER_W-1:0] timer_q,       timer_d;
  logic [CNT_W-1:0]   click_cnt_q,   click_cnt_d;
  logic               click_valid_q, click_valid_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    click_cnt_d   = click_cnt_q;
    click_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.key_pressed_stb_i) begin
          cnt_d   = CNT_W'(1);
          timer_d = '0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        // A press always wins over a coinciding timeout: it is counted and
        // the window restarts.
        if (bus.key_pressed_stb_i) begin
          if (cnt_q == CNT_W'(MAX_CLICKS - 1)) begin
            click_cnt_d   = CNT_W'(MAX_CLICKS);
            click_valid_d = 1'b1;
            state_d       = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            timer_d = '0;
          end
        end else if (timer_q == TIMER_W'(W - 1)) begin
          click_cnt_d   = cnt_q;
          click_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      timer_q       <= '0;
      click_cnt_q   <= '0;
      click_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      click_cnt_q   <= click_cnt_d;
      click_valid_q <= click_valid_d;
    end
  end

  assign bus.click_cnt_o   = click_cnt_q;
  assign bus.click_valid_o = click_valid_q;
  assign bus.busy_o        = (state_q == COUNT);

endmodule

// File: tb/tb_key_click_counter.sv
// Scoreboard bench for key_click_counter (W = 10 cycles, MAX_CLICKS = 3).
module tb_key_click_counter;
  import key_pkg::*;

  localparam int FREQ   = 1;
  localparam int WIN_US = 10;
  localparam int MAXC   = 3;
  localparam int WIN    = FREQ * WIN_US;
  localparam int CW     = $clog2(MAXC + 1);

  typedef struct {
    int edge_n;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_click_counter_if #(.CNT_W(CW)) bus ();

  key_click_counter #(
    .CLK_FREQ_MHZ(FREQ),
    .WINDOW_US   (WIN_US),
    .MAX_CLICKS  (MAXC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (timestamp based) ----------------
  int   edge_n = 0;
  int   grp    = 0;      // presses in the open group, 0 = no group
  int   last_press = 0;  // edge of the most recent press in the group
  ev_t  ev_q[$];         // expected click events
  bit   busy_q[$];       // expected busy after each edge

  always @(posedge rst) grp = 0;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      grp = 0;
    end else if (grp > 0) begin
      if (bus.key_pressed_stb_i) begin
        grp++;
        last_press = edge_n;
        if (grp == MAXC) begin
          ev_q.push_back('{edge_n, MAXC});
          grp = 0;
        end
      end else if (edge_n - last_press == WIN) begin
        ev_q.push_back('{edge_n, grp});
        grp = 0;
      end
    end else if (bus.key_pressed_stb_i) begin
      grp = 1;
      last_press = edge_n;
    end
    busy_q.push_back(grp > 0);
  end

  // ---------------- monitor ----------------
  ev_t obs_q[$];   // observed events, consumed by directed checks

  always @(posedge clk) begin
    ev_t e;
    bit  b;
    #1;
    if (busy_q.size() > 0) begin
      b = busy_q.pop_front();
      if (!rst) check("busy", int'(bus.busy_o), int'(b));
    end
    if (bus.click_valid_o) begin
      obs_q.push_back('{edge_n, int'(bus.click_cnt_o)});
      if (ev_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = ev_q.pop_front();
        check("valid_edge", edge_n, e.edge_n);
        check("click_cnt", int'(bus.click_cnt_o), e.cnt);
      end
    end else if (ev_q.size() > 0 && ev_q[0].edge_n <= edge_n) begin
      e = ev_q.pop_front();
      check("missing_valid", 0, 1);
    end
  end

  // ---------------- stimulus ----------------
  // Strobes at edges base+offs[i]; expected events at base+exp_e[j] with
  // count exp_c[j]. -1 pads unused entries.
  task automatic run_pattern(input string name, input int offs[4],
                             input int exp_e[2], input int exp_c[2],
                             input int len);
    int  base;
    int  nexp;
    bit  hit;
    @(negedge clk);
    base = edge_n;
    obs_q.delete();
    for (int i = 1; i <= len; i++) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++) if (offs[j] == i) hit = 1'b1;
      bus.key_pressed_stb_i = hit;
      @(negedge clk);
    end
    bus.key_pressed_stb_i = 1'b0;
    nexp = 0;
    for (int j = 0; j < 2; j++) if (exp_e[j] >= 0) nexp++;
    check({name, "_num_events"}, obs_q.size(), nexp);
    for (int j = 0; j < nexp && j < obs_q.size(); j++) begin
      check({name, "_edge"}, obs_q[j].edge_n - base, exp_e[j]);
      check({name, "_cnt"}, obs_q[j].cnt, exp_c[j]);
    end
    obs_q.delete();
  endtask

  initial begin
    int base;
    int p;
    int n_rand_ev;
    bus.key_pressed_stb_i = 1'b0;
    #1;
    check("reset_valid", int'(bus.click_valid_o), 0);
    check("reset_busy", int'(bus.busy_o), 0);
    check("reset_cnt", int'(bus.click_cnt_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_pattern("single",  '{5, -1, -1, -1}, '{15, -1}, '{1, -1}, 30);
    run_pattern("double",  '{5, 12, -1, -1}, '{22, -1}, '{2, -1}, 35);
    run_pattern("triple",  '{5, 8, 11, -1},  '{11, -1}, '{3, -1}, 30);
    run_pattern("coincide",'{5, 15, -1, -1}, '{25, -1}, '{2, -1}, 40);
    run_pattern("regroup", '{5, 8, 11, 12},  '{11, 22}, '{3, 1}, 40);

    // Reset in the middle of an open group.
    @(negedge clk);
    base = edge_n;
    obs_q.delete();
    for (int i = 1; i <= 40; i++) begin
      bus.key_pressed_stb_i = (i == 5);
      if (i == 8) begin
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", int'(bus.click_valid_o), 0);
        check("midrst_busy", int'(bus.busy_o), 0);
        check("midrst_cnt", int'(bus.click_cnt_o), 0);
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end
    bus.key_pressed_stb_i = 1'b0;
    check("midrst_no_valid", obs_q.size(), 0);
    obs_q.delete();

    // Random sparse strobes with varying density.
    p = 4;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) p = int'($urandom_range(2, 14));
      bus.key_pressed_stb_i = ($urandom_range(0, p - 1) == 0);
      @(negedge clk);
    end
    bus.key_pressed_stb_i = 1'b0;
    repeat (WIN + 3) @(negedge clk);
    n_rand_ev = obs_q.size();
    check("random_saw_events", int'(n_rand_ev > 20), 1);
    check("pending_events", ev_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
